pack_frame_fifo: RTL and testbench

Parametrised single-clock successor to the packet send buffer. Stores fixed-length frames of DW-bit words produced by the packet processor and presents them upstream through a valid/ready word interface. Adds frame commit/abort on the write side and rewind on the read side. Adds a drop-until-abort overflow policy with a saturating drop counter, a frame-level fill count and a stretched overflow indicator.

---
 rtl/pack_pkg.sv | 17 +
 rtl/pulse_stretch.sv | 28 ++
 rtl/pack_frame_fifo.sv | 107 ++++++++++
 tb/tb_pack_frame_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
// pack_pkg: shared pointer-width, frame-mask and saturation helpers for the frame FIFO
package pack_pkg;

    // Ceiling for any saturating counter; users slice it to their own width.
    localparam logic [31:0] SAT_ONES = '1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_w(input int depthlog2);
        return depthlog2 + 1;
    endfunction

    // Mask of the word-within-frame bits of a pointer.
    function automatic logic [31:0] frame_mask(input int framelog2);
        return (32'd1 << framelog2) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: holds out high for 2^STRETCHLOG2-1 cycles after trig drops
//   clk  : clock
//   rst  : asynchronous active-low reset
//   trig : level to stretch; reloads the counter every cycle it is high
//   out  : high while the counter is non-zero
module pulse_stretch #(
    parameter int STRETCHLOG2 = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic out
);

    logic [STRETCHLOG2-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = trig ? '1 : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign out = cnt_q != '0;

endmodule

// File: rtl/pack_frame_fifo.sv
// pack_frame_fifo: frame buffer with write commit/abort, read rewind and drop-until-abort overflow
//   clk         : clock
//   rst         : asynchronous active-low reset
//   wr_valid    : word offered by the packet processor
//   wr_data     : offered word
//   wr_abort    : discard the uncommitted partial frame and clear the drop latch
//   rd_data     : word at the read pointer (combinational)
//   rd_valid    : rd_data holds a committed word
//   rd_ready    : upstream takes rd_data this cycle
//   rd_rewind   : return the read pointer to the start of the current frame
//   frame_avail : at least one committed frame is held
//   frame_count : committed frames held, including a partially read one
//   overflow    : stretched indication that words are being dropped
//   drop_count  : saturating count of frames dropped
module pack_frame_fifo
    import pack_pkg::*;
#(
    parameter int DW          = 16,
    parameter int DEPTHLOG2   = 10,
    parameter int FRAMELOG2   = 3,
    parameter int STRETCHLOG2 = 26,
    parameter int CNTW        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [DW-1:0]                wr_data,
    input  logic                         wr_abort,
    output logic [DW-1:0]                rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    input  logic                         rd_rewind,
    output logic                         frame_avail,
    output logic [DEPTHLOG2-FRAMELOG2:0] frame_count,
    output logic                         overflow,
    output logic [CNTW-1:0]              drop_count
);

    localparam int PW    = ptr_w(DEPTHLOG2);
    localparam int FCW   = DEPTHLOG2 - FRAMELOG2 + 1;
    localparam int DEPTH = 1 << DEPTHLOG2;
    localparam logic [PW-1:0]   FULL_LVL = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = SAT_ONES[CNTW-1:0];
    localparam logic [31:0]     FMASK    = frame_mask(FRAMELOG2);

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0]   wp_q, wp_d, wcp_q, wcp_d, rp_q, rp_d, rcp_q, rcp_d;
    logic            drop_q, drop_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]   wp_inc, rp_inc, fill;
    logic            full, we, hs, drop_evt;

    always_comb begin
        wp_inc   = wp_q + 1'b1;
        rp_inc   = rp_q + 1'b1;
        // Space is reclaimed only when a whole frame is consumed, so a rewind never sees overwritten data.
        full     = (wp_q - rcp_q) == FULL_LVL;
        we       = wr_valid && !wr_abort && !drop_q && !full;
        drop_evt = wr_valid && !wr_abort && !drop_q && full;
        wp_d     = wr_abort ? wcp_q : we ? wp_inc : wp_q;
        wcp_d    = (we && (32'(wp_inc) & FMASK) == '0) ? wp_inc : wcp_q;
        // Once a word is lost the rest of the frame is useless, so keep dropping until the writer aborts.
        drop_d   = !wr_abort && (drop_q || drop_evt);
        drop_cnt_d = (drop_evt && drop_cnt_q != CNT_MAX) ? drop_cnt_q + 1'b1 : drop_cnt_q;
        hs       = rd_valid && rd_ready && !rd_rewind;
        rp_d     = rd_rewind ? rcp_q : hs ? rp_inc : rp_q;
        rcp_d    = (hs && (32'(rp_inc) & FMASK) == '0) ? rp_inc : rcp_q;
        fill     = wcp_q - rcp_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q       <= '0;
            wcp_q      <= '0;
            rp_q       <= '0;
            rcp_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wp_q       <= wp_d;
            wcp_q      <= wcp_d;
            rp_q       <= rp_d;
            rcp_q      <= rcp_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wp_q[DEPTHLOG2-1:0]] <= wr_data;
    end

    pulse_stretch #(.STRETCHLOG2(STRETCHLOG2)) u_stretch (
        .clk  (clk),
        .rst  (rst),
        .trig (drop_q),
        .out  (overflow)
    );

    assign rd_valid    = rp_q != wcp_q;
    assign rd_data     = mem[rp_q[DEPTHLOG2-1:0]];
    assign frame_count = FCW'(fill >> FRAMELOG2);
    assign frame_avail = frame_count != '0;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_pack_frame_fifo.sv
// tb_pack_frame_fifo: directed scenario bench for pack_frame_fifo
module tb_pack_frame_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid = 1'b0, wr_abort = 1'b0, rd_ready = 1'b0, rd_rewind = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_valid, frame_avail, overflow;
    logic [2:0]  frame_count;
    logic [15:0] drop_count;

    logic        w2_valid = 1'b0, w2_abort = 1'b0, r2_ready = 1'b0, r2_rewind = 1'b0;
    logic [15:0] w2_data = '0;
    logic [15:0] rd2_data;
    logic        rd2_valid, fa2, ov2;
    logic [2:0]  fc2;
    logic [1:0]  dc2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pack_frame_fifo #(.DW(16), .DEPTHLOG2(4), .FRAMELOG2(2), .STRETCHLOG2(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_abort(wr_abort),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rewind(rd_rewind),
        .frame_avail(frame_avail), .frame_count(frame_count), .overflow(overflow),
        .drop_count(drop_count)
    );

    pack_frame_fifo #(.DW(16), .DEPTHLOG2(4), .FRAMELOG2(2), .STRETCHLOG2(4), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .wr_valid(w2_valid), .wr_data(w2_data), .wr_abort(w2_abort),
        .rd_data(rd2_data), .rd_valid(rd2_valid), .rd_ready(r2_ready), .rd_rewind(r2_rewind),
        .frame_avail(fa2), .frame_count(fc2), .overflow(ov2), .drop_count(dc2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total += 5;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        if (frame_avail !== 1'b0) begin bad++; $display("FAIL reset_frame_avail got=%b exp=0", frame_avail); end
        if (frame_count !== 3'd0) begin bad++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'hA0 + 16'(i);
            step();
            if (i == 2) begin
                total += 2;
                if (frame_count !== 3'd0) begin bad++; $display("FAIL basic_partial_count got=%0d exp=0", frame_count); end
                if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_partial_valid got=%b exp=0", rd_valid); end
            end
        end
        wr_valid = 1'b0;
        total += 2;
        if (frame_avail !== 1'b1) begin bad++; $display("FAIL basic_frame_avail got=%b exp=1", frame_avail); end
        if (frame_count !== 3'd1) begin bad++; $display("FAIL basic_frame_count got=%0d exp=1", frame_count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total += 2;
            if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_rd_valid[%0d] got=%b exp=1", i, rd_valid); end
            if (rd_data !== 16'hA0 + 16'(i)) begin bad++; $display("FAIL basic_rd_data[%0d] got=%h exp=%h", i, rd_data, 16'hA0 + 16'(i)); end
            step();
        end
        rd_ready = 1'b0;
        total += 2;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_empty_valid got=%b exp=0", rd_valid); end
        if (frame_count !== 3'd0) begin bad++; $display("FAIL basic_empty_count got=%0d exp=0", frame_count); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'hB0 + 16'(i);
            step();
        end
        wr_abort = 1'b1;
        wr_data = 16'hBF;
        step();
        wr_abort = 1'b0;
        wr_valid = 1'b0;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL abort_nothing_committed got=%b exp=0", rd_valid); end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'hC0 + 16'(i);
            step();
        end
        wr_valid = 1'b0;
        total++;
        if (frame_count !== 3'd1) begin bad++; $display("FAIL abort_frame_count got=%0d exp=1", frame_count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data !== 16'hC0 + 16'(i)) begin bad++; $display("FAIL abort_rd_data[%0d] got=%h exp=%h", i, rd_data, 16'hC0 + 16'(i)); end
            step();
        end
        rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL abort_empty got=%b exp=0", rd_valid); end
    endtask

    task automatic test_rewind();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'hD0 + 16'(i);
            step();
        end
        wr_valid = 1'b0;
        rd_rewind = 1'b1;
        step();
        rd_rewind = 1'b0;
        total++;
        if (rd_data !== 16'hD0) begin bad++; $display("FAIL rewind_noop got=%h exp=00d0", rd_data); end
        rd_ready = 1'b1;
        step();
        step();
        total++;
        if (rd_data !== 16'hD2) begin bad++; $display("FAIL rewind_before got=%h exp=00d2", rd_data); end
        rd_rewind = 1'b1;
        step();
        rd_rewind = 1'b0;
        total += 2;
        if (rd_data !== 16'hD0) begin bad++; $display("FAIL rewind_data got=%h exp=00d0", rd_data); end
        if (frame_count !== 3'd1) begin bad++; $display("FAIL rewind_count got=%0d exp=1", frame_count); end
        for (int i = 0; i < 3; i++) begin
            step();
            total += 2;
            if (frame_count !== 3'd1) begin bad++; $display("FAIL rewind_hold_count[%0d] got=%0d exp=1", i, frame_count); end
            if (rd_data !== 16'hD1 + 16'(i)) begin bad++; $display("FAIL rewind_reread[%0d] got=%h exp=%h", i, rd_data, 16'hD1 + 16'(i)); end
        end
        step();
        rd_ready = 1'b0;
        total++;
        if (frame_count !== 3'd0) begin bad++; $display("FAIL rewind_freed got=%0d exp=0", frame_count); end
    endtask

    task automatic test_full_drop();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'hE0 + 16'(i);
            step();
        end
        total += 2;
        if (frame_count !== 3'd3) begin bad++; $display("FAIL full_frame_count got=%0d exp=3", frame_count); end
        if (drop_count !== 16'd0) begin bad++; $display("FAIL full_no_drop_yet got=%0d exp=0", drop_count); end
        wr_data = 16'hEF;
        step();
        total += 2;
        if (drop_count !== 16'd1) begin bad++; $display("FAIL full_drop_count got=%0d exp=1", drop_count); end
        if (frame_count !== 3'd3) begin bad++; $display("FAIL full_count_after_drop got=%0d exp=3", frame_count); end
        wr_data = 16'h55;
        step();
        step();
        total += 2;
        if (drop_count !== 16'd1) begin bad++; $display("FAIL full_drop_hold got=%0d exp=1", drop_count); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", overflow); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data !== 16'hE0 + 16'(i)) begin bad++; $display("FAIL full_rd_data[%0d] got=%h exp=%h", i, rd_data, 16'hE0 + 16'(i)); end
            step();
        end
        rd_ready = 1'b0;
        total += 2;
        if (frame_count !== 3'd2) begin bad++; $display("FAIL full_after_read_count got=%0d exp=2", frame_count); end
        if (drop_count !== 16'd1) begin bad++; $display("FAIL full_latched_drop got=%0d exp=1", drop_count); end
        wr_valid = 1'b0;
        wr_abort = 1'b1;
        step();
        wr_abort = 1'b0;
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow_after_abort got=%b exp=1", overflow); end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'hF0 + 16'(i);
            step();
        end
        wr_valid = 1'b0;
        total++;
        if (frame_count !== 3'd3) begin bad++; $display("FAIL full_resume_count got=%0d exp=3", frame_count); end
        repeat (10) step();
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL stretch_14 got=%b exp=1", overflow); end
        step();
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL stretch_15 got=%b exp=0", overflow); end
        rd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [15:0] exp;
            exp = (i < 8) ? 16'hE4 + 16'(i) : 16'hF0 + 16'(i - 8);
            total++;
            if (rd_data !== exp) begin bad++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, rd_data, exp); end
            step();
        end
        rd_ready = 1'b0;
        total += 2;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL full_drain_empty got=%b exp=0", rd_valid); end
        if (frame_count !== 3'd0) begin bad++; $display("FAIL full_drain_count got=%0d exp=0", frame_count); end
    endtask

    task automatic test_saturation();
        for (int n = 1; n <= 5; n++) begin
            logic [1:0] exp;
            for (int j = 0; j < ((n == 1) ? 15 : 3); j++) begin
                w2_valid = 1'b1;
                w2_data = 16'(j);
                step();
            end
            step();
            w2_valid = 1'b0;
            w2_abort = 1'b1;
            step();
            w2_abort = 1'b0;
            exp = (n < 3) ? 2'(n) : 2'd3;
            total++;
            if (dc2 !== exp) begin bad++; $display("FAIL sat_drop_count[%0d] got=%0d exp=%0d", n, dc2, exp); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'h70 + 16'(i);
            step();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        step();
        total += 4;
        if (rd_data !== 16'h71) begin bad++; $display("FAIL arst_pre_data got=%h exp=0071", rd_data); end
        if (drop_count !== 16'd1) begin bad++; $display("FAIL arst_pre_drop got=%0d exp=1", drop_count); end
        if (ov2 !== 1'b1) begin bad++; $display("FAIL arst_pre_overflow got=%b exp=1", ov2); end
        if (dc2 !== 2'd3) begin bad++; $display("FAIL arst_pre_dc2 got=%0d exp=3", dc2); end
        #3 rst = 1'b0;
        #1;
        total += 6;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL arst_rd_valid got=%b exp=0", rd_valid); end
        if (frame_avail !== 1'b0) begin bad++; $display("FAIL arst_frame_avail got=%b exp=0", frame_avail); end
        if (frame_count !== 3'd0) begin bad++; $display("FAIL arst_frame_count got=%0d exp=0", frame_count); end
        if (drop_count !== 16'd0) begin bad++; $display("FAIL arst_drop_count got=%0d exp=0", drop_count); end
        if (ov2 !== 1'b0) begin bad++; $display("FAIL arst_overflow got=%b exp=0", ov2); end
        if (dc2 !== 2'd0) begin bad++; $display("FAIL arst_dc2 got=%0d exp=0", dc2); end
        rd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'h90 + 16'(i);
            step();
        end
        wr_valid = 1'b0;
        total += 2;
        if (frame_count !== 3'd1) begin bad++; $display("FAIL arst_resume_count got=%0d exp=1", frame_count); end
        if (rd_data !== 16'h90) begin bad++; $display("FAIL arst_resume_data got=%h exp=0090", rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_rewind();
        test_full_drop();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
